// File: rtl/addn_pipe_if.sv
// Stream interface for addn_pipe: operand/carry input with valid/ready and sum output with valid/ready.
// The sub field exists only when ADDN_PIPE_SUB_EN is defined.
interface addn_pipe_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef ADDN_PIPE_SUB_EN
  logic             sub;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;

  modport master (
    output in_valid, a, b, cin,
`ifdef ADDN_PIPE_SUB_EN
    output sub,
`endif
    output out_ready,
    input  in_ready, out_valid, sum
  );

  modport slave (
    input  in_valid, a, b, cin,
`ifdef ADDN_PIPE_SUB_EN
    input  sub,
`endif
    input  out_ready,
    output in_ready, out_valid, sum
  );
endinterface

// File: rtl/addn_pipe.sv
// Pipelined WIDTH-bit adder, one CHUNK-bit slice per stage, carry registered between stages.
// Optional subtract mode (a + ~b + 1) is enabled by the ADDN_PIPE_SUB_EN macro.
module addn_pipe #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic        clk,
  input  logic        rst,
  addn_pipe_if.slave  bus
);
  localparam int unsigned STAGES = WIDTH / CHUNK;
  localparam int unsigned AW     = CHUNK + 1;

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef ADDN_PIPE_SUB_EN
  // Subtraction folds into the adder as a + ~b + 1; cin is ignored then.
  assign b_eff   = bus.sub ? ~bus.b : bus.b;
  assign cin_eff = bus.sub ? 1'b1 : bus.cin;
`else
  assign b_eff   = bus.b;
  assign cin_eff = bus.cin;
`endif

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int unsigned IW = WIDTH - k * CHUNK;   // operand bits still to be added
    localparam int unsigned SW = (k + 1) * CHUNK;     // result bits produced so far

    logic [IW-1:0] a_hi;
    logic [IW-1:0] b_hi;
    logic          c_in;
    logic          v_in;
    logic [AW-1:0] add;
    logic [SW-1:0] s_d;
    logic [SW-1:0] s_q;
    logic          c_q;
    logic          v_q;

    assign add = AW'(a_hi[CHUNK-1:0]) + AW'(b_hi[CHUNK-1:0]) + AW'(c_in);

    if (k == 0) begin : g_first
      assign a_hi = bus.a;
      assign b_hi = b_eff;
      assign c_in = cin_eff;
      assign v_in = bus.in_valid;
      assign s_d  = add[CHUNK-1:0];
    end else begin : g_next
      // Skew registers: upper operand slices travel alongside the carry.
      logic [IW-1:0] a_q;
      logic [IW-1:0] b_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (!stall) begin
          a_q <= g_stage[k-1].a_hi[CHUNK +: IW];
          b_q <= g_stage[k-1].b_hi[CHUNK +: IW];
        end
      end

      assign a_hi = a_q;
      assign b_hi = b_q;
      assign c_in = g_stage[k-1].c_q;
      assign v_in = g_stage[k-1].v_q;
      assign s_d  = {add[CHUNK-1:0], g_stage[k-1].s_q};
    end

    // Stage result: lower slices are carried along so the full sum lands together.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (!stall) begin
        v_q <= v_in;
        c_q <= add[CHUNK];
        s_q <= s_d;
      end
    end
  end

  assign bus.out_valid = g_stage[STAGES-1].v_q;
  assign bus.sum       = {g_stage[STAGES-1].c_q, g_stage[STAGES-1].s_q};
  assign stall         = bus.out_valid & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
endmodule

// File: tb/tb_addn_pipe.sv
// Directed, table-driven bench for addn_pipe at 16/4, 4/1 (exhaustive) and 8/8 (single stage).
module tb_addn_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  addn_pipe_if #(.WIDTH(16)) if16 ();
  addn_pipe_if #(.WIDTH(4))  if4 ();
  addn_pipe_if #(.WIDTH(8))  if8 ();

  addn_pipe #(.WIDTH(16), .CHUNK(4)) dut16 (.clk(clk), .rst(rst), .bus(if16));
  addn_pipe #(.WIDTH(4),  .CHUNK(1)) dut4  (.clk(clk), .rst(rst), .bus(if4));
  addn_pipe #(.WIDTH(8),  .CHUNK(8)) dut8  (.clk(clk), .rst(rst), .bus(if8));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [16:0] exp;
  } vec16_t;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [8:0] exp;
  } vec8_t;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [16:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic cin);
    return 17'(a) + 17'(b) + 17'(cin);
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec16_t      vecs[8];
    vec8_t       v8[3];
    logic [16:0] q[$];
    logic [4:0]  q4[$];
    logic [16:0] held;
    int          lat, got, first, last, stale;

    vecs[0] = '{16'hFFFF, 16'h0001, 1'b0, 17'h10000};
    vecs[1] = '{16'hFFFF, 16'hFFFF, 1'b1, 17'h1FFFF};
    vecs[2] = '{16'h0000, 16'h0000, 1'b0, 17'h00000};
    vecs[3] = '{16'h1234, 16'h4321, 1'b1, 17'h05556};
    vecs[4] = '{16'h8000, 16'h8000, 1'b0, 17'h10000};
    vecs[5] = '{16'h0FFF, 16'h0000, 1'b1, 17'h01000};
    vecs[6] = '{16'h00F0, 16'h0F10, 1'b0, 17'h01000};
    vecs[7] = '{16'h0005, 16'h0007, 1'b0, 17'h0000C};
    v8[0]   = '{8'hFF, 8'h01, 1'b0, 9'h100};
    v8[1]   = '{8'hFF, 8'hFF, 1'b1, 9'h1FF};
    v8[2]   = '{8'h12, 8'h34, 1'b1, 9'h047};

    rst = 1'b1;
    if16.in_valid = 1'b0; if16.a = '0; if16.b = '0; if16.cin = 1'b0; if16.out_ready = 1'b1;
    if4.in_valid  = 1'b0; if4.a  = '0; if4.b  = '0; if4.cin  = 1'b0; if4.out_ready  = 1'b1;
    if8.in_valid  = 1'b0; if8.a  = '0; if8.b  = '0; if8.cin  = 1'b0; if8.out_ready  = 1'b1;
`ifdef ADDN_PIPE_SUB_EN
    if16.sub = 1'b0; if4.sub = 1'b0; if8.sub = 1'b0;
`endif

    // Reset state
    #12;
    check("rst_out_valid", 32'(if16.out_valid), 32'd0);
    check("rst_sum", 32'(if16.sum), 32'd0);
    step();
    rst = 1'b0;
    #1;
    check("rst_in_ready", 32'(if16.in_ready), 32'd1);

    // Single operations: latency and carry ripple
    for (int i = 0; i < 8; i++) begin
      if16.a = vecs[i].a; if16.b = vecs[i].b; if16.cin = vecs[i].cin; if16.in_valid = 1'b1;
      step();
      if16.in_valid = 1'b0;
      lat = 1;
      while (!if16.out_valid && lat < 10) begin
        step();
        lat++;
      end
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd4);
      check($sformatf("vec%0d_sum", i), 32'(if16.sum), 32'(vecs[i].exp));
      step();
    end
    check("idle_out_valid", 32'(if16.out_valid), 32'd0);

    // Streaming: 8 back-to-back transfers
    got = 0; first = -1; last = -1;
    for (int s = 0; s < 16; s++) begin
      if (s < 8) begin
        if16.a = 16'(s); if16.b = 16'(32'h1000 * s); if16.cin = 1'b0; if16.in_valid = 1'b1;
        q.push_back(ref_add(if16.a, if16.b, 1'b0));
      end else begin
        if16.in_valid = 1'b0;
      end
      step();
      if (if16.out_valid) begin
        if (q.size() == 0) check("stream_extra", 32'(if16.sum), 32'hFFFF_FFFF);
        else check($sformatf("stream%0d_sum", got), 32'(if16.sum), 32'(q.pop_front()));
        got++;
        if (first < 0) first = s;
        last = s;
      end
    end
    check("stream_count", 32'(got), 32'd8);
    check("stream_first_cycle", 32'(first), 32'd3);
    check("stream_back_to_back", 32'(last - first), 32'd7);

    // Backpressure: 3 in flight, stall 5 clocks while offering junk input
    q.delete();
    for (int i = 0; i < 3; i++) begin
      if16.a = 16'(32'h0100 * (i + 1)); if16.b = 16'h00FF; if16.cin = 1'b1; if16.in_valid = 1'b1;
      q.push_back(ref_add(if16.a, if16.b, 1'b1));
      step();
    end
    if16.in_valid = 1'b0;
    if16.out_ready = 1'b0;
    step();
    held = q[0];
    check("bp_out_valid", 32'(if16.out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      if16.a = 16'hAAAA; if16.b = 16'h5555; if16.cin = 1'b1; if16.in_valid = 1'b1;
      step();
      check($sformatf("bp_hold%0d_valid", c), 32'(if16.out_valid), 32'd1);
      check($sformatf("bp_hold%0d_sum", c), 32'(if16.sum), 32'(held));
      check($sformatf("bp_hold%0d_in_ready", c), 32'(if16.in_ready), 32'd0);
    end
    if16.in_valid = 1'b0;
    if16.out_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 10; t++) begin
      #1;
      if (if16.out_valid) begin
        if (q.size() == 0) check("bp_extra", 32'(if16.sum), 32'hFFFF_FFFF);
        else check($sformatf("bp_drain%0d_sum", got), 32'(if16.sum), 32'(q.pop_front()));
        got++;
      end
      step();
    end
    check("bp_drain_count", 32'(got), 32'd3);

    // Reset mid-flight
    for (int i = 1; i <= 2; i++) begin
      if16.a = 16'(i); if16.b = 16'(i); if16.cin = 1'b0; if16.in_valid = 1'b1;
      step();
    end
    if16.in_valid = 1'b0;
    step();
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 32'(if16.out_valid), 32'd0);
    check("midrst_sum", 32'(if16.sum), 32'd0);
    step();
    rst = 1'b0;
    stale = 0;
    for (int t = 0; t < 8; t++) begin
      step();
      if (if16.out_valid) stale++;
    end
    check("midrst_no_stale", 32'(stale), 32'd0);
    if16.a = 16'd5; if16.b = 16'd7; if16.cin = 1'b0; if16.in_valid = 1'b1;
    step();
    if16.in_valid = 1'b0;
    lat = 1;
    while (!if16.out_valid && lat < 10) begin
      step();
      lat++;
    end
    check("midrst_new_latency", 32'(lat), 32'd4);
    check("midrst_new_sum", 32'(if16.sum), 32'd12);
    step();

    // Exhaustive WIDTH=4, CHUNK=1
    got = 0;
    for (int s = 0; s < 520; s++) begin
      if (s < 512) begin
        logic [8:0] v;
        v = 9'(s);
        if4.a = v[3:0]; if4.b = v[7:4]; if4.cin = v[8]; if4.in_valid = 1'b1;
        q4.push_back(5'(v[3:0]) + 5'(v[7:4]) + 5'(v[8]));
      end else begin
        if4.in_valid = 1'b0;
      end
      step();
      if (if4.out_valid) begin
        if (q4.size() == 0) check("w4_extra", 32'(if4.sum), 32'hFFFF_FFFF);
        else check($sformatf("w4_vec%0d_sum", got), 32'(if4.sum), 32'(q4.pop_front()));
        got++;
      end
    end
    check("w4_count", 32'(got), 32'd512);

    // Single stage WIDTH=8, CHUNK=8: latency 1
    for (int i = 0; i < 3; i++) begin
      if8.a = v8[i].a; if8.b = v8[i].b; if8.cin = v8[i].cin; if8.in_valid = 1'b1;
      step();
      if8.in_valid = 1'b0;
      check($sformatf("w8_vec%0d_valid", i), 32'(if8.out_valid), 32'd1);
      check($sformatf("w8_vec%0d_sum", i), 32'(if8.sum), 32'(v8[i].exp));
      step();
      check($sformatf("w8_vec%0d_drained", i), 32'(if8.out_valid), 32'd0);
    end

`ifdef ADDN_PIPE_SUB_EN
    // Subtract mode, then alternating sub/add back-to-back
    q.delete();
    got = 0;
    for (int s = 0; s < 14; s++) begin
      if (s < 8) begin
        logic [15:0] nb;
        if16.sub = (s == 0 || s == 1) ? 1'b1 : 1'(s % 2);
        if16.a = (s == 0) ? 16'h0003 : (s == 1) ? 16'h0005 : 16'(32'h0321 * s);
        if16.b = (s == 0) ? 16'h0005 : (s == 1) ? 16'h0003 : 16'(32'h0777 * s);
        if16.cin = 1'b1;
        if16.in_valid = 1'b1;
        nb = ~if16.b;
        q.push_back(if16.sub ? (17'(if16.a) + 17'(nb) + 17'd1) : ref_add(if16.a, if16.b, 1'b1));
      end else begin
        if16.in_valid = 1'b0;
      end
      step();
      if (if16.out_valid) begin
        if (got == 0)      check("sub_3_minus_5", 32'(if16.sum), 32'h0FFFE);
        else if (got == 1) check("sub_5_minus_3", 32'(if16.sum), 32'h10002);
        if (q.size() == 0) check("sub_extra", 32'(if16.sum), 32'hFFFF_FFFF);
        else check($sformatf("sub%0d_sum", got), 32'(if16.sum), 32'(q.pop_front()));
        got++;
      end
    end
    if16.sub = 1'b0;
    check("sub_count", 32'(got), 32'd8);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
